// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencer and its synchroniser.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    SYNC    = 3'd0,
    HOLD    = 3'd1,
    RELEASE = 3'd2,
    DONE    = 3'd3
  } state_e;

  // Counter width able to hold values 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reset_sync_nstage.sv
// Async-assert / sync-deassert reset synchroniser of STAGES flops.
// sync_n rises STAGES edges after async_reset_n deasserts; it falls immediately on assertion.
module reset_sync_nstage #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic async_reset_n,
  output logic sync_n
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], 1'b1};
  end

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_n = sync_q[STAGES-1];

endmodule

// File: rtl/reset_seq_ctrl.sv
// Reset sequencer: synchronised release, minimum hold, then in-order gated release of NUM_CH channels.
// ch0 rises MIN_HOLD edges after hold starts; later channels follow at REL_GAP spacing, stalling on rel_ready.
module reset_seq_ctrl
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_CH      = 4,
  parameter int MIN_HOLD    = 16,
  parameter int REL_GAP     = 4
) (
  input  logic              clk,
  input  logic              async_reset_n,
  input  logic              sw_rst_req,
  input  logic [NUM_CH-1:0] rel_ready,
  output logic [NUM_CH-1:0] ch_rst_n,
  output logic              busy,
  output logic              done,
  output logic [2:0]        state
);

  localparam int HW = cnt_w(MIN_HOLD + 1);
  localparam int GW = cnt_w(REL_GAP + 1);
  localparam int IW = cnt_w(NUM_CH);

  localparam logic [HW-1:0] HOLD_LOAD = HW'(MIN_HOLD - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(REL_GAP - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_CH - 1);

  logic sync_n;

  state_e            state_q,    state_d;
  logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
  logic [GW-1:0]     gap_cnt_q,  gap_cnt_d;
  logic [IW-1:0]     idx_q,      idx_d;
  logic [NUM_CH-1:0] ch_rst_n_q, ch_rst_n_d;
  logic              done_q,     done_d;
  logic              busy_q,     busy_d;
  logic              rel_step;

  reset_sync_nstage #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk           (clk),
    .async_reset_n (async_reset_n),
    .sync_n        (sync_n)
  );

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    idx_d      = idx_q;
    ch_rst_n_d = ch_rst_n_q;
    done_d     = done_q;
    busy_d     = busy_q;
    rel_step   = 1'b0;

    case (state_q)
      SYNC: begin
        if (sync_n) begin
          state_d    = HOLD;
          hold_cnt_d = HOLD_LOAD;
        end
      end
      HOLD: begin
        // The edge that finds the hold expired is also ch0's first release opportunity,
        // so ch0 rises exactly MIN_HOLD edges after the hold was loaded.
        if (hold_cnt_q != '0) begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end else begin
          state_d  = RELEASE;
          rel_step = 1'b1;
        end
      end
      RELEASE: rel_step = 1'b1;
      DONE:    ;
      default: state_d = SYNC;
    endcase

    if (rel_step) begin
      if (gap_cnt_q != '0) begin
        gap_cnt_d = gap_cnt_q - 1'b1;
      end else if (rel_ready[idx_q]) begin
        ch_rst_n_d[idx_q] = 1'b1;
        gap_cnt_d         = GAP_LOAD;
        if (idx_q == IDX_LAST) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
    end

    // Software request overrides any release on the same edge.
    if (sw_rst_req && (state_q != SYNC)) begin
      state_d    = HOLD;
      hold_cnt_d = HOLD_LOAD;
      gap_cnt_d  = '0;
      idx_d      = '0;
      ch_rst_n_d = '0;
      done_d     = 1'b0;
      busy_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state_q    <= SYNC;
      hold_cnt_q <= '0;
      gap_cnt_q  <= '0;
      idx_q      <= '0;
      ch_rst_n_q <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      idx_q      <= idx_d;
      ch_rst_n_q <= ch_rst_n_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign ch_rst_n = ch_rst_n_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign state    = state_q;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Directed bench for reset_seq_ctrl: default build plus a minimal-parameter build.
module tb_reset_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst0_n, rst1_n;
  logic       sw0, sw1;
  logic [3:0] rdy0;
  logic       rdy1;
  logic [3:0] ch0_n;
  logic       busy0, done0;
  logic [2:0] st0;
  logic       ch1_n;
  logic       busy1, done1;
  logic [2:0] st1;

  always #5 clk = ~clk;

  reset_seq_ctrl u_dut0 (
    .clk           (clk),
    .async_reset_n (rst0_n),
    .sw_rst_req    (sw0),
    .rel_ready     (rdy0),
    .ch_rst_n      (ch0_n),
    .busy          (busy0),
    .done          (done0),
    .state         (st0)
  );

  reset_seq_ctrl #(
    .SYNC_STAGES (3),
    .NUM_CH      (1),
    .MIN_HOLD    (1),
    .REL_GAP     (1)
  ) u_dut1 (
    .clk           (clk),
    .async_reset_n (rst1_n),
    .sw_rst_req    (sw1),
    .rel_ready     (rdy1),
    .ch_rst_n      (ch1_n),
    .busy          (busy1),
    .done          (done1),
    .state         (st1)
  );

  typedef struct {
    int         e;
    logic [3:0] ch;
    logic       done;
    logic       busy;
    logic [2:0] st;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   cyc;
  int   which;
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic exp_t rst_exp();
    exp_t r;
    r.e = 0; r.ch = 4'b0000; r.done = 1'b0; r.busy = 1'b1; r.st = 3'd0;
    return r;
  endfunction

  task automatic push(input int e, input logic [3:0] ch, input logic d,
                      input logic b, input logic [2:0] s);
    exp_t x;
    x.e = e; x.ch = ch; x.done = d; x.busy = b; x.st = s;
    q.push_back(x);
  endtask

  // Default-parameter release schedule with all permits high.
  task automatic push_std();
    push(2,  4'b0000, 1'b0, 1'b1, 3'd1);
    push(18, 4'b0001, 1'b0, 1'b1, 3'd2);
    push(22, 4'b0011, 1'b0, 1'b1, 3'd2);
    push(26, 4'b0111, 1'b0, 1'b1, 3'd2);
    push(30, 4'b1111, 1'b1, 1'b0, 3'd3);
  endtask

  task automatic check(input string tag);
    logic [3:0] ch;
    logic       d, b;
    logic [2:0] s;
    if (which == 0) begin
      ch = ch0_n; d = done0; b = busy0; s = st0;
    end else begin
      ch = {3'b000, ch1_n}; d = done1; b = busy1; s = st1;
    end
    vectors++;
    assert ({ch, d, b, s} === {cur.ch, cur.done, cur.busy, cur.st}) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed ch=%b done=%b busy=%b st=%0d expected ch=%b done=%b busy=%b st=%0d",
             tag, cyc, ch, d, b, s, cur.ch, cur.done, cur.busy, cur.st);
    end
  endtask

  task automatic run_to(input int last, input string tag);
    while (cyc < last) begin
      @(posedge clk);
      cyc++;
      #1;
      while (q.size() > 0 && q[0].e <= cyc) cur = q.pop_front();
      check(tag);
    end
  endtask

  // Assert reset between edges and confirm the outputs respond without a clock.
  task automatic assert_rst0(input string tag);
    #2;
    rst0_n = 1'b0;
    #1;
    q.delete();
    cur = rst_exp();
    check(tag);
  endtask

  task automatic release_rst(input int w);
    @(negedge clk);
    if (w == 0) rst0_n = 1'b1;
    else        rst1_n = 1'b1;
    cyc = -1;
  endtask

  initial begin
    rst0_n = 1'b1; rst1_n = 1'b1;
    sw0 = 1'b0; sw1 = 1'b0;
    rdy0 = 4'hF; rdy1 = 1'b1;
    which = 0;
    cur = rst_exp();
    #1;
    rst0_n = 1'b0; rst1_n = 1'b0;
    #1;
    check("reset_init0");
    which = 1;
    check("reset_init1");
    which = 0;
    cyc = -4;
    run_to(-1, "reset_held");

    // 1: default release; sw request while still in SYNC must be ignored.
    push_std();
    release_rst(0);
    sw0 = 1'b1;
    run_to(1, "t1_sw_in_sync");
    sw0 = 1'b0;
    run_to(32, "t1_release");

    // 2: ch2 permit withheld until edge 40.
    assert_rst0("t2_async");
    rdy0 = 4'b1011;
    push(2,  4'b0000, 1'b0, 1'b1, 3'd1);
    push(18, 4'b0001, 1'b0, 1'b1, 3'd2);
    push(22, 4'b0011, 1'b0, 1'b1, 3'd2);
    push(41, 4'b0111, 1'b0, 1'b1, 3'd2);
    push(45, 4'b1111, 1'b1, 1'b0, 3'd3);
    release_rst(0);
    run_to(40, "t2_stall");
    rdy0 = 4'hF;
    run_to(50, "t2_resume");

    // 3: software request from DONE at edge 100.
    run_to(99, "t3_done");
    push(100, 4'b0000, 1'b0, 1'b1, 3'd1);
    push(116, 4'b0001, 1'b0, 1'b1, 3'd2);
    push(120, 4'b0011, 1'b0, 1'b1, 3'd2);
    push(124, 4'b0111, 1'b0, 1'b1, 3'd2);
    push(128, 4'b1111, 1'b1, 1'b0, 3'd3);
    sw0 = 1'b1;
    run_to(100, "t3_sw");
    sw0 = 1'b0;
    run_to(130, "t3_rerun");

    // 4: software request at edge 24 with ch0/ch1 already released.
    assert_rst0("t4_async");
    push(2,  4'b0000, 1'b0, 1'b1, 3'd1);
    push(18, 4'b0001, 1'b0, 1'b1, 3'd2);
    push(22, 4'b0011, 1'b0, 1'b1, 3'd2);
    push(24, 4'b0000, 1'b0, 1'b1, 3'd1);
    push(40, 4'b0001, 1'b0, 1'b1, 3'd2);
    push(44, 4'b0011, 1'b0, 1'b1, 3'd2);
    push(48, 4'b0111, 1'b0, 1'b1, 3'd2);
    push(52, 4'b1111, 1'b1, 1'b0, 3'd3);
    release_rst(0);
    run_to(23, "t4_pre");
    sw0 = 1'b1;
    run_to(24, "t4_sw");
    sw0 = 1'b0;
    run_to(54, "t4_rerun");

    // 5: async reset pulses mid-HOLD and mid-RELEASE.
    assert_rst0("t5_async");
    push_std();
    release_rst(0);
    run_to(10, "t5_hold");
    assert_rst0("t5_mid_hold");
    push_std();
    release_rst(0);
    run_to(25, "t5_rel");
    assert_rst0("t5_mid_rel");
    push_std();
    release_rst(0);
    run_to(32, "t5_full");

    // 6: minimal-parameter build.
    which = 1;
    cur = rst_exp();
    check("t6_reset");
    push(3, 4'b0000, 1'b0, 1'b1, 3'd1);
    push(4, 4'b0001, 1'b1, 1'b0, 3'd3);
    release_rst(1);
    run_to(10, "t6_min");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
